// File: rtl/uart_vram_loader.sv
// UART (8N1) packet loader that writes the charmap/chardata RAMs through port A.
// Packet: CMD ('M' or 'D'), ADDR_HI, ADDR_LO, LEN (0 = 256), then LEN data bytes.
module uart_vram_loader #(
    parameter int CLKS_PER_BIT = 108,
    parameter int TIMEOUT_CLKS = 2500000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        rx,
    output logic [15:0] address,
    output logic [7:0]  data_w,
    output logic        charmap_we,
    output logic        chardat_we,
    output logic        busy,
    output logic        pkt_done,
    output logic        err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int TW = $clog2(TIMEOUT_CLKS);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLKS - 1);
    localparam logic [7:0] CMD_M = 8'h4D;
    localparam logic [7:0] CMD_D = 8'h44;

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_e;
    typedef enum logic [2:0] {
        P_IDLE, P_AHI, P_ALO, P_LEN, P_DATA, P_WRITE
    } pkt_state_e;

    logic rx_s1_q, rx_s2_q, rx_s3_q;

    rx_state_e rs_q, rs_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] sh_q, sh_d;
    logic bv_q, bv_d;
    logic fe_q, fe_d;

    pkt_state_e ps_q, ps_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0] data_q, data_d;
    logic mwe_q, mwe_d, dwe_q, dwe_d;
    logic sel_q, sel_d;
    logic [8:0] rem_q, rem_d;
    logic busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic timeout;

    always_comb begin
        rs_d  = rs_q;
        cnt_d = cnt_q;
        bit_d = bit_q;
        sh_d  = sh_q;
        bv_d  = 1'b0;
        fe_d  = 1'b0;
        unique case (rs_q)
            R_IDLE: begin
                if (rx_s3_q && !rx_s2_q) begin
                    rs_d  = R_START;
                    cnt_d = HALF;
                end
            end
            R_START: begin
                if (cnt_q == '0) begin
                    if (rx_s2_q) begin
                        rs_d = R_IDLE;
                    end else begin
                        rs_d  = R_DATA;
                        cnt_d = FULL;
                        bit_d = 3'd0;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            R_DATA: begin
                if (cnt_q == '0) begin
                    sh_d  = {rx_s2_q, sh_q[7:1]};
                    cnt_d = FULL;
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) rs_d = R_STOP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            R_STOP: begin
                if (cnt_q == '0) begin
                    bv_d = rx_s2_q;
                    fe_d = !rx_s2_q;
                    rs_d = R_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: rs_d = R_IDLE;
        endcase
    end

    always_comb begin
        ps_d    = ps_q;
        addr_d  = addr_q;
        data_d  = data_q;
        mwe_d   = 1'b0;
        dwe_d   = 1'b0;
        sel_d   = sel_q;
        rem_d   = rem_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        tmo_d   = tmo_q;
        timeout = 1'b0;
        // A byte arriving on the expiry cycle takes priority over the timeout.
        if (ps_q == P_IDLE || bv_q) begin
            tmo_d = '0;
        end else if (tmo_q == TMO_LAST) begin
            timeout = 1'b1;
        end else begin
            tmo_d = tmo_q + 1'b1;
        end
        unique case (ps_q)
            P_IDLE: begin
                if (bv_q) begin
                    unique case (1'b1)
                        (sh_q == CMD_M): begin
                            sel_d  = 1'b0;
                            busy_d = 1'b1;
                            ps_d   = P_AHI;
                        end
                        (sh_q == CMD_D): begin
                            sel_d  = 1'b1;
                            busy_d = 1'b1;
                            ps_d   = P_AHI;
                        end
                        default: err_d = 1'b1;
                    endcase
                end
            end
            P_AHI: begin
                if (bv_q) begin
                    addr_d[15:8] = sh_q;
                    ps_d = P_ALO;
                end
            end
            P_ALO: begin
                if (bv_q) begin
                    addr_d[7:0] = sh_q;
                    ps_d = P_LEN;
                end
            end
            P_LEN: begin
                if (bv_q) begin
                    rem_d = (sh_q == 8'd0) ? 9'd256 : {1'b0, sh_q};
                    ps_d  = P_DATA;
                end
            end
            P_DATA: begin
                if (bv_q) begin
                    data_d = sh_q;
                    mwe_d  = !sel_q;
                    dwe_d  = sel_q;
                    ps_d   = P_WRITE;
                end
            end
            P_WRITE: begin
                addr_d = addr_q + 16'd1;
                rem_d  = rem_q - 9'd1;
                if (rem_q == 9'd1) begin
                    done_d = 1'b1;
                    busy_d = 1'b0;
                    ps_d   = P_IDLE;
                end else begin
                    ps_d = P_DATA;
                end
            end
            default: ps_d = P_IDLE;
        endcase
        if (fe_q || timeout) begin
            err_d = 1'b1;
            if (ps_q != P_IDLE) begin
                busy_d = 1'b0;
                done_d = 1'b0;
                mwe_d  = 1'b0;
                dwe_d  = 1'b0;
                ps_d   = P_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
            rx_s3_q <= 1'b1;
            rs_q    <= R_IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            sh_q    <= 8'd0;
            bv_q    <= 1'b0;
            fe_q    <= 1'b0;
            ps_q    <= P_IDLE;
            addr_q  <= 16'd0;
            data_q  <= 8'd0;
            mwe_q   <= 1'b0;
            dwe_q   <= 1'b0;
            sel_q   <= 1'b0;
            rem_q   <= 9'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            tmo_q   <= '0;
        end else begin
            rx_s1_q <= rx;
            rx_s2_q <= rx_s1_q;
            rx_s3_q <= rx_s2_q;
            rs_q    <= rs_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            bv_q    <= bv_d;
            fe_q    <= fe_d;
            ps_q    <= ps_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            mwe_q   <= mwe_d;
            dwe_q   <= dwe_d;
            sel_q   <= sel_d;
            rem_q   <= rem_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
        end
    end

    assign address    = addr_q;
    assign data_w     = data_q;
    assign charmap_we = mwe_q;
    assign chardat_we = dwe_q;
    assign busy       = busy_q;
    assign pkt_done   = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_uart_vram_loader.sv
// Directed bench for uart_vram_loader: packets sent bit-serially on rx,
// RAM writes captured at the falling clock edge and compared with hand-made lists.
module tb_uart_vram_loader;

    localparam int CPB = 16;
    localparam int TMO = 1000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        rx;
    logic [15:0] address;
    logic [7:0]  data_w;
    logic        charmap_we, chardat_we, busy, pkt_done, err;

    uart_vram_loader #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TMO)) dut (
        .clk(clk), .reset_n(reset_n), .rx(rx),
        .address(address), .data_w(data_w),
        .charmap_we(charmap_we), .chardat_we(chardat_we),
        .busy(busy), .pkt_done(pkt_done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [7:0]  d;
        logic        m;
    } wr_t;

    wr_t wq[$];
    int  cyc = 0;
    int  done_cnt = 0, err_cnt = 0, both_cnt = 0;
    int  last_we_cyc = 0, done_cyc = 0, err_cyc = 0;
    int  n_cmp = 0, n_bad = 0;
    logic [7:0] seq[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset_n) begin
            if (charmap_we || chardat_we) begin
                wq.push_back('{a: address, d: data_w, m: charmap_we});
                last_we_cyc = cyc;
            end
            if (charmap_we && chardat_we) both_cnt++;
            if (pkt_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (err) begin
                err_cnt++;
                err_cyc = cyc;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop;
        repeat (CPB) @(negedge clk);
        if (!stop) begin
            rx = 1'b1;
            repeat (CPB) @(negedge clk);
        end
    endtask

    task automatic send_seq();
        foreach (seq[i]) send_byte(seq[i]);
        repeat (6) @(negedge clk);
    endtask

    task automatic check_wr(input string tag, input int idx,
                            input logic [15:0] a, input logic [7:0] d,
                            input logic m);
        if (idx < wq.size()) begin
            check(tag, {7'd0, wq[idx].m, wq[idx].d, wq[idx].a},
                  {7'd0, m, d, a});
        end else begin
            check(tag, 32'hDEAD, {7'd0, m, d, a});
        end
    endtask

    int wb, db, eb, bad;
    bit seen;

    initial begin
        reset_n = 1'b0;
        rx = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_addr", 32'(address), 32'h0);
        check("rst_outs", {24'd0, data_w}, 32'h0);
        check("rst_flags", {27'd0, charmap_we, chardat_we, busy, pkt_done, err},
              32'h0);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        // Basic charmap packet
        wb = wq.size(); db = done_cnt; eb = err_cnt;
        send_byte(8'h4D);
        check("busy_after_cmd", 32'(busy), 32'h1);
        seq = '{8'h01, 8'h20, 8'h03, 8'hAA, 8'hBB, 8'hCC};
        send_seq();
        check("p1_count", 32'(wq.size() - wb), 32'd3);
        check_wr("p1_w0", wb + 0, 16'h0120, 8'hAA, 1'b1);
        check_wr("p1_w1", wb + 1, 16'h0121, 8'hBB, 1'b1);
        check_wr("p1_w2", wb + 2, 16'h0122, 8'hCC, 1'b1);
        check("p1_done", 32'(done_cnt - db), 32'd1);
        check("p1_done_lat", 32'(done_cyc - last_we_cyc), 32'd1);
        check("p1_busy", 32'(busy), 32'h0);
        check("p1_err", 32'(err_cnt - eb), 32'd0);
        check("p1_addr_hold", 32'(address), 32'h0123);

        // Chardata with 16-bit address wrap
        wb = wq.size(); db = done_cnt;
        seq = '{8'h44, 8'hFF, 8'hFF, 8'h02, 8'h11, 8'h22};
        send_seq();
        check("p2_count", 32'(wq.size() - wb), 32'd2);
        check_wr("p2_w0", wb + 0, 16'hFFFF, 8'h11, 1'b0);
        check_wr("p2_w1", wb + 1, 16'h0000, 8'h22, 1'b0);
        check("p2_done", 32'(done_cnt - db), 32'd1);

        // LEN = 0 means 256 bytes
        wb = wq.size(); db = done_cnt;
        seq = '{8'h44, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 256; i++) seq.push_back(8'(i));
        send_seq();
        check("p3_count", 32'(wq.size() - wb), 32'd256);
        bad = 0;
        for (int i = 0; i < 256 && wb + i < wq.size(); i++) begin
            if (wq[wb+i].a !== 16'(i) || wq[wb+i].d !== 8'(i) ||
                wq[wb+i].m !== 1'b0) bad++;
        end
        check("p3_content_bad", 32'(bad), 32'd0);
        check("p3_done", 32'(done_cnt - db), 32'd1);
        check("p3_addr_hold", 32'(address), 32'h0100);

        // Bad command, then a normal one
        wb = wq.size(); eb = err_cnt;
        seq = '{8'h58};
        send_seq();
        check("bad_cmd_err", 32'(err_cnt - eb), 32'd1);
        check("bad_cmd_busy", 32'(busy), 32'h0);
        seq = '{8'h4D, 8'h00, 8'h10, 8'h01, 8'h5A};
        send_seq();
        check("p4_count", 32'(wq.size() - wb), 32'd1);
        check_wr("p4_w0", wb, 16'h0010, 8'h5A, 1'b1);

        // Frame error on a data byte aborts the packet
        wb = wq.size(); eb = err_cnt; db = done_cnt;
        seq = '{8'h4D, 8'h00, 8'h30, 8'h02};
        send_seq();
        send_byte(8'h77, 1'b0);
        repeat (6) @(negedge clk);
        check("fe_err", 32'(err_cnt - eb), 32'd1);
        check("fe_writes", 32'(wq.size() - wb), 32'd0);
        check("fe_busy", 32'(busy), 32'h0);
        check("fe_done", 32'(done_cnt - db), 32'd0);

        // Short low glitch is not a start bit
        eb = err_cnt;
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB / 4) @(negedge clk);
        rx = 1'b1;
        repeat (CPB * 12) @(negedge clk);
        check("glitch_err", 32'(err_cnt - eb), 32'd0);
        check("glitch_busy", 32'(busy), 32'h0);

        // Silence mid-packet times out
        wb = wq.size(); eb = err_cnt;
        seq = '{8'h4D, 8'h00, 8'h00, 8'h05, 8'h01, 8'h02};
        foreach (seq[i]) send_byte(seq[i]);
        begin
            int t0;
            t0 = cyc;
            for (int i = 0; i < TMO + 4 * CPB && err_cnt == eb; i++)
                @(negedge clk);
            check("tmo_err", 32'(err_cnt - eb), 32'd1);
            check("tmo_window",
                  32'((err_cyc - t0) >= TMO - 2 * CPB && (err_cyc - t0) <= TMO),
                  32'd1);
        end
        repeat (3) @(negedge clk);
        check("tmo_writes", 32'(wq.size() - wb), 32'd2);
        check("tmo_busy", 32'(busy), 32'h0);

        // Reset while a write strobe is high
        seq = '{8'h4D, 8'h00, 8'h40, 8'h04};
        foreach (seq[i]) send_byte(seq[i]);
        seen = 1'b0;
        fork
            send_byte(8'h33);
            begin
                for (int i = 0; i < CPB * 12 && !seen; i++) begin
                    @(negedge clk);
                    if (charmap_we) seen = 1'b1;
                end
                if (seen) begin
                    #1 reset_n = 1'b0;
                    #1;
                end
            end
        join
        check("rst_we_seen", 32'(seen), 32'd1);
        check("rst_mid_flags",
              {27'd0, charmap_we, chardat_we, busy, pkt_done, err}, 32'h0);
        check("rst_mid_addr", {address, data_w}, 32'h0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        wb = wq.size();
        seq = '{8'h66, 8'h77};
        send_seq();
        check("post_rst_writes", 32'(wq.size() - wb), 32'd0);
        check("post_rst_busy", 32'(busy), 32'h0);

        check("never_both_we", 32'(both_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
